ctz_iterative_unit: RTL and testbench
=====================================

Name: ctz_iterative_unit

Overview:
Multi-cycle count-trailing-zeros / count-trailing-ones unit. It is the LSB-first counterpart of the combinational leading-zero counter and serves the ALU's bit-scan extension ops. It scans a latched operand from bit 0 upward, SCAN_BITS bits per cycle, with early exit. The execute stage drives it through a start/busy/done handshake, like the other multicycle units.

Parameters:
DATA_WIDTH, 32, operand width; must be a multiple of SCAN_BITS.
SCAN_BITS, 4, bits examined per SCAN cycle; power of two, 1..DATA_WIDTH.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
i_start  input  1  request pulse; sampled only in IDLE or DONE.
i_data  input  DATA_WIDTH  operand; sampled on the accepting edge only.
i_count_ones  input  1  0 = count trailing zeros, 1 = count trailing ones; sampled with i_start.
i_flush  input  1  pipeline flush; aborts any operation.
o_busy  output  1  high in SCAN.
o_done  output  1  one-cycle pulse: o_result is newly valid.
o_result  output  32  trailing count, zero-extended; bits [31:$clog2(DATA_WIDTH)+1] always 0.

Behaviour:
- States: IDLE, SCAN, DONE. Registers: shift_reg[DATA_WIDTH], count (enough bits to hold DATA_WIDTH), o_result.
- Reset (asynchronous, any state, mid-scan included): state=IDLE, o_busy=0, o_done=0, o_result=0, count=0, shift_reg=0.
- Accept: state in {IDLE, DONE} and i_start=1 and i_flush=0.
  - shift_reg <= i_count_ones ? ~i_data : i_data; count <= 0; next state SCAN.
  - The counting-ones case is therefore counting trailing zeros of the inverted operand.
- SCAN cycle: let low = shift_reg[SCAN_BITS-1:0].
  - If low != 0: o_result <= count + (trailing zeros of low). Next state DONE.
  - If low == 0 and count + SCAN_BITS == DATA_WIDTH: o_result <= DATA_WIDTH (operand is all-zero, or all-ones for CTO). Next state DONE.
  - Otherwise: shift_reg <= shift_reg >> SCAN_BITS; count <= count + SCAN_BITS; stay in SCAN.
- DONE: o_done=1 for exactly this cycle. Next state is SCAN if a new request is accepted, else IDLE.
- o_done and o_busy are registered state decodes; they are never high together.
- o_result holds its last value until the next completing SCAN cycle.
  - It does not change on accept, flush or idle cycles.
  - It does change on reset (to 0).
- Latency, for start accepted at edge 0:
  - m SCAN cycles, where m = floor(tz/SCAN_BITS)+1 for tz < DATA_WIDTH, and m = DATA_WIDTH/SCAN_BITS for tz = DATA_WIDTH.
  - o_done is high in cycle m+1.
  - Defaults: best case 2 cycles, worst case 9 cycles.
- i_start while in SCAN: ignored; no queuing, no effect on the running operation.
- i_flush = 1:
  - Next state IDLE from any state. A same-cycle i_start is not accepted.
  - A completion that would happen in that SCAN cycle is discarded: o_result is not updated and o_done does not pulse.
  - If o_done is already high in DONE, it still completes its single cycle.
- Back-to-back operation: a start in DONE is accepted, giving done-to-done spacing of m+1 cycles.

Test Plan:
- Reset mid-scan: start with i_data=0x80000000, assert reset in the 3rd SCAN cycle -> outputs drop immediately (asynchronous): o_busy=0, o_done=0, o_result=0. After release, state is IDLE.
- CTZ best and worst case: i_data=0x00000001 -> o_done in cycle 2, o_result=0. i_data=0x80000000 -> o_done in cycle 9, o_result=31. i_data=0x00000100 -> o_done in cycle 4, o_result=8.
- Boundary values: i_data=0x00000000 with CTZ -> o_result=32 in cycle 9. i_data=0xFFFFFFFF with i_count_ones=1 -> o_result=32. i_data=0x0000FFFF with i_count_ones=1 -> o_result=16 in cycle 6.
- Handshake:
  - Assert i_start again during SCAN of 0x00010000 -> ignored; o_result=16.
  - Then start 0x00000004 in the DONE cycle -> accepted; o_done again 2 cycles later with o_result=2; o_busy and o_done never both high.
- Flush: start 0x00100000, assert i_flush in SCAN cycle 6 (the completing cycle) -> no o_done. o_result keeps its prior value. State IDLE; o_busy=0 next cycle.
- Randomised compare: 1000 random operands mixed with i_count_ones, plus SCAN_BITS in {1,4,8} builds -> o_result matches a reference count. The cycle of o_done matches the latency formula exactly.

Source files
------------

// File: rtl/ctz_iterative_unit.sv
// rtl/ctz_iterative_unit.sv - multi-cycle count-trailing-zeros/ones unit with early exit
module ctz_iterative_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SCAN_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_count_ones,
  input  logic                  i_flush,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [31:0]           o_result
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - SCAN_BITS);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] STEP       = CW'(SCAN_BITS);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         result_q, result_d;
  logic [SCAN_BITS-1:0]  low;
  logic                  accept;

  function automatic logic [CW-1:0] low_tz(input logic [SCAN_BITS-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = SCAN_BITS - 1; i >= 0; i--) begin
      if (v[i]) r = CW'(i);
    end
    return r;
  endfunction

  assign low    = shift_q[SCAN_BITS-1:0];
  assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && i_start && !i_flush;

  // Counting ones is counting zeros of the inverted operand.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    count_d  = count_q;
    result_d = result_q;
    case (state_q)
      S_SCAN: begin
        if (i_flush) begin
          state_d = S_IDLE;
        end else if (low != '0) begin
          result_d = count_q + low_tz(low);
          state_d  = S_DONE;
        end else if (count_q == LAST_COUNT) begin
          result_d = FULL_COUNT;
          state_d  = S_DONE;
        end else begin
          shift_d = shift_q >> SCAN_BITS;
          count_d = count_q + STEP;
        end
      end
      default: begin
        if (accept) begin
          shift_d = i_count_ones ? ~i_data : i_data;
          count_d = '0;
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign o_busy   = (state_q == S_SCAN);
  assign o_done   = (state_q == S_DONE);
  assign o_result = {{(32 - CW){1'b0}}, result_q};

endmodule

// File: tb/tb_ctz_iterative_unit.sv
// tb/tb_ctz_iterative_unit.sv - self-checking bench for ctz_iterative_unit
module tb_ctz_iterative_unit;

  localparam int DW = 32;
  localparam int SB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_count_ones = 1'b0;
  logic          i_flush = 1'b0;
  logic          o_busy;
  logic          o_done;
  logic [31:0]   o_result;

  int n_cmp = 0;
  int n_bad = 0;

  ctz_iterative_unit #(.DATA_WIDTH(DW), .SCAN_BITS(SB)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_data(i_data),
    .i_count_ones(i_count_ones), .i_flush(i_flush),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_tz(input logic [DW-1:0] d, input logic ones);
    logic [DW-1:0] v;
    v = ones ? ~d : d;
    for (int i = 0; i < DW; i++) if (v[i]) return i;
    return DW;
  endfunction

  function automatic int scan_cycles(input int tz);
    return (tz < DW) ? (tz / SB + 1) : (DW / SB);
  endfunction

  // Inputs as seen by the DUT at each rising edge.
  logic          cap_reset = 1'b1, cap_start = 1'b0, cap_ones = 1'b0, cap_flush = 1'b0;
  logic [DW-1:0] cap_data = '0;
  always @(posedge clk) begin
    cap_reset = reset;
    cap_start = i_start;
    cap_data  = i_data;
    cap_ones  = i_count_ones;
    cap_flush = i_flush;
  end

  // Model: remaining scan cycles, done pulse, held result.
  int          m_left = 0;
  int          m_pend = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = '0;
  always @(negedge clk) begin
    if (reset || cap_reset) begin
      m_left = 0; m_done = 1'b0; m_result = '0;
    end else if (m_left > 0) begin
      if (cap_flush) begin
        m_left = 0; m_done = 1'b0;
      end else if (m_left == 1) begin
        m_left = 0; m_done = 1'b1; m_result = 32'(m_pend);
      end else begin
        m_left--; m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (cap_start && !cap_flush) begin
        m_pend = ref_tz(cap_data, cap_ones);
        m_left = scan_cycles(m_pend);
      end
    end
    chk("model_busy", {31'd0, o_busy}, {31'd0, m_left > 0});
    chk("model_done", {31'd0, o_done}, {31'd0, m_done});
    chk("model_result", o_result, m_result);
    chk("busy_and_done", {31'd0, o_busy & o_done}, 32'd0);
  end

  // Starts an op, returns at the negedge of the done cycle (or after the bound).
  task automatic run_op(input string name, input logic [DW-1:0] data, input logic ones,
                        input int poke, input int flush, input int exp_cyc, input logic [31:0] exp_res);
    int cyc;
    int got;
    i_start = 1'b1; i_data = data; i_count_ones = ones;
    @(negedge clk);
    i_start = 1'b0; i_data = $urandom; i_count_ones = $urandom_range(0, 1);
    cyc = 1;
    got = 0;
    while (cyc < 20) begin
      if (o_done) begin
        got = cyc;
        break;
      end
      i_start = (cyc == poke);
      if (cyc == poke) i_data = 32'h1;
      i_flush = (cyc == flush);
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0;
    i_flush = 1'b0;
    chk({name, "_cycle"}, 32'(got), 32'(exp_cyc));
    chk({name, "_result"}, o_result, exp_res);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    chk("reset_done", {31'd0, o_done}, 32'd0);
    chk("reset_result", o_result, 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);

    run_op("ctz_1",        32'h0000_0001, 1'b0, 0, 0, 2, 32'd0);
    run_op("ctz_msb",      32'h8000_0000, 1'b0, 0, 0, 9, 32'd31);
    run_op("ctz_100",      32'h0000_0100, 1'b0, 0, 0, 4, 32'd8);
    run_op("ctz_zero",     32'h0000_0000, 1'b0, 0, 0, 9, 32'd32);
    run_op("cto_ones",     32'hFFFF_FFFF, 1'b1, 0, 0, 9, 32'd32);
    run_op("cto_ffff",     32'h0000_FFFF, 1'b1, 0, 0, 6, 32'd16);
    run_op("start_in_scan", 32'h0001_0000, 1'b0, 2, 0, 6, 32'd16);
    run_op("back_to_back", 32'h0000_0004, 1'b0, 0, 0, 2, 32'd2);
    run_op("flush",        32'h0010_0000, 1'b0, 0, 6, 0, 32'd2);
    chk("flush_idle", {31'd0, o_busy}, 32'd0);

    i_data = 32'h8000_0000; i_count_ones = 1'b0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", {31'd0, o_busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_busy", {31'd0, o_busy}, 32'd0);
    chk("async_reset_done", {31'd0, o_done}, 32'd0);
    chk("async_reset_result", o_result, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", {31'd0, o_busy}, 32'd0);

    for (int k = 0; k < 1000; k++) begin
      logic [DW-1:0] d;
      logic          ones;
      int            tz;
      d = $urandom;
      d = d << $urandom_range(0, 32);
      ones = $urandom_range(0, 1);
      if (ones) d = ~d;
      tz = ref_tz(d, ones);
      run_op("random", d, ones, 0, 0, scan_cycles(tz) + 1, 32'(tz));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
